muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide execute unit. It sits directly downstream of the register file read ports, taking rs1/rs2 read data, and directly upstream of the register file write port. It performs one M-extension operation at a time with a fixed 32-cycle iteration. It signals busy so the core stalls issue, then presents the result on write-port-compatible outputs for one cycle.

---
 rtl/muldiv_unit.sv | 161 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit per
// cycle, with the result presented on register-file write-port outputs for one cycle.
module muldiv_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  input  logic [4:0]        rd_addr,
  output logic              busy,
  output logic              done,
  output logic              rg_wrt_en,
  output logic [4:0]        rg_wrt_addr,
  output logic [DATA_W-1:0] rg_wrt_data
);

  localparam int unsigned CntW = $clog2(DATA_W);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [4:0]          rd_q, rd_d;
  logic                neg_q, neg_d;
  logic [DATA_W-1:0]   opnd_q, opnd_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   res_q, res_d;

  // Operand decode at issue
  logic              is_div, a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
  logic [DATA_W-1:0] a_mag, b_mag;

  always_comb begin
    is_div   = funct3[2];
    a_signed = is_div ? !funct3[0] : (funct3 != 3'd3);
    b_signed = is_div ? !funct3[0] : !funct3[1];
    a_neg    = a_signed & rs1_data[DATA_W-1];
    b_neg    = b_signed & rs2_data[DATA_W-1];
    a_mag    = a_neg ? -rs1_data : rs1_data;
    b_mag    = b_neg ? -rs2_data : rs2_data;
    div_zero = is_div && (rs2_data == '0);
    div_ovf  = is_div && !funct3[0] && (rs1_data == {1'b1, {(DATA_W-1){1'b0}}}) &&
               (rs2_data == '1);
  end

  // One iteration of the selected algorithm
  logic [DATA_W:0]     add_hi, shifted;
  logic [DATA_W-1:0]   diff, quo_step, rem_step;
  logic                lt;
  logic [2*DATA_W-1:0] acc_step, prod;
  logic [DATA_W-1:0]   quo_fix, rem_fix, final_res;

  always_comb begin
    add_hi  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, opnd_q};
    shifted = {rem_q, acc_q[DATA_W-1]};
    lt      = shifted < {1'b0, opnd_q};
    // When no borrow, the true difference is below the divisor and fits in DATA_W bits
    diff     = shifted[DATA_W-1:0] - opnd_q;
    rem_step = lt ? shifted[DATA_W-1:0] : diff;
    quo_step = {acc_q[DATA_W-2:0], !lt};
    if (op_q[2]) begin
      acc_step = {acc_q[2*DATA_W-1:DATA_W], quo_step};
    end else if (acc_q[0]) begin
      acc_step = {add_hi, acc_q[DATA_W-1:1]};
    end else begin
      acc_step = {1'b0, acc_q[2*DATA_W-1:1]};
    end
    prod    = neg_q ? -acc_step : acc_step;
    quo_fix = neg_q ? -acc_step[DATA_W-1:0] : acc_step[DATA_W-1:0];
    rem_fix = neg_q ? -rem_step : rem_step;
    if (op_q[2]) begin
      final_res = op_q[1] ? rem_fix : quo_fix;
    end else begin
      final_res = (op_q[1:0] == 2'd0) ? prod[DATA_W-1:0] : prod[2*DATA_W-1:DATA_W];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rd_d    = rd_q;
    neg_d   = neg_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    res_d   = res_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d   = funct3;
          rd_d   = rd_addr;
          cnt_d  = '0;
          // Remainder follows the dividend; product and quotient follow the sign mismatch
          neg_d  = (is_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);
          opnd_d = is_div ? b_mag : a_mag;
          acc_d  = {{DATA_W{1'b0}}, (is_div ? a_mag : b_mag)};
          rem_d  = '0;
          if (div_zero) begin
            res_d   = funct3[1] ? rs1_data : '1;
            state_d = StDone;
          end else if (div_ovf) begin
            res_d   = funct3[1] ? '0 : rs1_data;
            state_d = StDone;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        acc_d = acc_step;
        rem_d = rem_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(DATA_W - 1)) begin
          res_d   = final_res;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      neg_q   <= 1'b0;
      opnd_q  <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      neg_q   <= neg_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    busy        = (state_q != StIdle);
    done        = (state_q == StDone);
    rg_wrt_en   = done && (rd_q != 5'd0);
    rg_wrt_addr = rd_q;
    rg_wrt_data = res_q;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table of RV32M ops plus hand-written sequences for
// busy-time start rejection and mid-operation reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_addr;
  logic        busy, done, rg_wrt_en;
  logic [4:0]  rg_wrt_addr;
  logic [31:0] rg_wrt_data;

  int checks = 0;
  int failures = 0;

  muldiv_unit #(.DATA_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .funct3      (funct3),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .rd_addr     (rd_addr),
    .busy        (busy),
    .done        (done),
    .rg_wrt_en   (rg_wrt_en),
    .rg_wrt_addr (rg_wrt_addr),
    .rg_wrt_data (rg_wrt_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " busy"}, {31'b0, busy}, 32'd0);
    check({tag, " done"}, {31'b0, done}, 32'd0);
    check({tag, " wrt_en"}, {31'b0, rg_wrt_en}, 32'd0);
    check({tag, " wrt_addr"}, {27'b0, rg_wrt_addr}, 32'd0);
    check({tag, " wrt_data"}, rg_wrt_data, 32'd0);
  endtask

  // Called at a negedge; returns at the negedge of the cycle after done
  task automatic run_op(input vec_t v, input string name);
    int  cyc;
    logic busy_ok;
    funct3   = v.f3;
    rs1_data = v.a;
    rs2_data = v.b;
    rd_addr  = v.rd;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    rs1_data = ~v.a;
    rs2_data = 32'h0000_0000;
    rd_addr  = ~v.rd;
    funct3   = ~v.f3;
    busy_ok  = 1'b1;
    cyc      = 1;
    @(negedge clk);
    while (!done && cyc < 40) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    if (!busy) busy_ok = 1'b0;
    check({name, " latency"}, 32'(cyc), 32'(v.lat));
    check({name, " busy held"}, {31'b0, busy_ok}, 32'd1);
    check({name, " data"}, rg_wrt_data, v.exp);
    check({name, " wrt_en"}, {31'b0, rg_wrt_en}, {31'b0, (v.rd != 5'd0)});
    check({name, " wrt_addr"}, {27'b0, rg_wrt_addr}, {27'b0, v.rd});
    @(negedge clk);
    check({name, " done after"}, {30'b0, busy, done}, 32'd0);
  endtask

  initial begin
    int cyc;
    logic saw_done;
    vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000, 33};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 33};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3,  32'hFFFF_FFFF, 33};
    vecs[4]  = '{3'd5, 32'd100,       32'd7,         5'd4,  32'd14,        33};
    vecs[5]  = '{3'd7, 32'd100,       32'd7,         5'd6,  32'd2,         33};
    vecs[6]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd7,  32'hFFFF_FFFD, 33};
    vecs[7]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd8,  32'hFFFF_FFFF, 33};
    vecs[8]  = '{3'd4, 32'h0000_0055, 32'h0000_0000, 5'd9,  32'hFFFF_FFFF, 1};
    vecs[9]  = '{3'd7, 32'h0000_1234, 32'h0000_0000, 5'd10, 32'h0000_1234, 1};
    vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1};
    vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0000_0000, 1};
    vecs[12] = '{3'd0, 32'h0000_0003, 32'h0000_0004, 5'd0,  32'h0000_000C, 33};
    vecs[13] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 32'h0000_0000, 33};
    vecs[14] = '{3'd3, 32'h8000_0000, 32'h0000_0002, 5'd14, 32'h0000_0001, 33};
    vecs[15] = '{3'd6, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd15, 32'hFFFF_FFFF, 33};
    vecs[16] = '{3'd5, 32'hFFFF_FFFF, 32'h0000_0001, 5'd16, 32'hFFFF_FFFF, 33};
    vecs[17] = '{3'd4, 32'h1234_5678, 32'hFFFF_FF00, 5'd17, 32'hFFED_CBAA, 33};
    vecs[18] = '{3'd2, 32'hFFFF_FFFE, 32'h8000_0000, 5'd18, 32'hFFFF_FFFF, 33};
    vecs[19] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h0000_0000, 33};

    reset    = 1'b1;
    start    = 1'b0;
    funct3   = 3'd0;
    rs1_data = '0;
    rs2_data = '0;
    rd_addr  = '0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Starts during CALC (cycle 5) and DONE (cycle 33) must be ignored
    funct3   = 3'd0;
    rs1_data = 32'h0000_0007;
    rs2_data = 32'hFFFF_FFFD;
    rd_addr  = 5'd5;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    funct3   = 3'd5;
    rs1_data = 32'd100;
    rs2_data = 32'd7;
    rd_addr  = 5'd9;
    cyc      = 1;
    @(negedge clk);
    while (!done && cyc < 40) begin
      start = (cyc == 5);
      @(negedge clk);
      cyc++;
    end
    start = 1'b1;
    check("ignore latency", 32'(cyc), 32'd33);
    check("ignore data", rg_wrt_data, 32'hFFFF_FFEB);
    check("ignore addr", {27'b0, rg_wrt_addr}, 32'd5);
    @(negedge clk);
    start = 1'b0;
    check("ignore idle at 34", {30'b0, busy, done}, 32'd0);
    check("ignore data held", rg_wrt_data, 32'hFFFF_FFEB);
    run_op(vecs[4], "accept at 34");

    // Reset in the middle of a divide abandons it
    funct3   = 3'd4;
    rs1_data = 32'd100;
    rs2_data = 32'd7;
    rd_addr  = 5'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("busy before reset", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check_idle_outputs("mid reset");
    @(negedge clk);
    reset    = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("no done after reset", {31'b0, saw_done}, 32'd0);
    run_op(vecs[6], "after reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
